tow_match_ctrl: RTL and testbench



---
 rtl/tow_pkg.sv | 31 +++
 rtl/tow_hold_timer.sv | 31 +++
 rtl/tow_match_ctrl.sv | 118 +++++++++++
 tb/tb_tow_match_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war match controller slice.
package tow_pkg;

    localparam int SCORE_W = 3;

    // Match sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        HOLD  = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } tow_state_e;

    // Round / match result codes.
    typedef logic [1:0] winner_t;
    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;
    localparam winner_t WIN_DRAW = 2'b11;

    // Saturating score increment: never passes max_s, never wraps.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] max_s);
        if (s >= max_s) begin
            return max_s;
        end
        return s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/tow_hold_timer.sv
// Loadable down-counter that times how long a round result stays on the field.
// load wins over en; the counter parks at zero and done stays high there.
module tow_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

    logic [W-1:0] count;

    // Load on entry to the hold window, then count down to zero and stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tow_match_ctrl.sv
// Match-level sequencer for tug-of-war: enables play, clears the field
// between rounds, tallies round wins and declares the champion.
// Presses are single-cycle pulses; win1/win2 are levels that are only
// looked at while the FSM is in PLAY. There is no back-pressure.
module tow_match_ctrl
    import tow_pkg::*;
#(
    parameter int unsigned MAX_SCORE   = 7,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1_press,
    input  logic               p2_press,
    input  logic               win1,
    input  logic               win2,
    output logic               play_en,
    output logic               field_reset,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         round_winner,
    output logic               match_over,
    output logic [1:0]         champion
);

    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

    tow_state_e state;
    tow_state_e state_next;
    logic       hold_done;
    logic       round_end;
    logic       match_won;

    // The computer's press never starts or ends a match.
    logic unused_p2;
    assign unused_p2 = p2_press;

    assign round_end = (state == PLAY) && (win1 || win2);
    assign match_won = (score1 == MAX_S) || (score2 == MAX_S);

    tow_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .load  (round_end),
        .en    (state == HOLD),
        .done  (hold_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (p1_press) state_next = PLAY;
            PLAY:    if (win1 || win2) state_next = HOLD;
            HOLD:    if (hold_done) state_next = match_won ? DONE : CLEAR;
            CLEAR:   state_next = PLAY;
            DONE:    if (p1_press) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        play_en     = (state == PLAY);
        field_reset = (state == IDLE) || (state == CLEAR);
        match_over  = (state == DONE);
    end

    // Score, round result and champion registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score1       <= '0;
            score2       <= '0;
            round_winner <= WIN_NONE;
            champion     <= WIN_NONE;
        end else begin
            case (state)
                PLAY: begin
                    if (win1 && !win2) begin
                        score1       <= sat_inc(score1, MAX_S);
                        round_winner <= WIN_P1;
                    end else if (win2 && !win1) begin
                        score2       <= sat_inc(score2, MAX_S);
                        round_winner <= WIN_P2;
                    end else if (win1 && win2) begin
                        round_winner <= WIN_DRAW;
                    end
                end
                HOLD: begin
                    if (hold_done && match_won) begin
                        champion <= (score1 == MAX_S) ? WIN_P1 : WIN_P2;
                    end
                end
                DONE: begin
                    if (p1_press) begin
                        score1       <= '0;
                        score2       <= '0;
                        round_winner <= WIN_NONE;
                        champion     <= WIN_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed bench for tow_match_ctrl with MAX_SCORE=3 and HOLD_CYCLES=8.
module tb_tow_match_ctrl;

    localparam int MAX  = 3;
    localparam int HOLD = 8;

    logic       clk;
    logic       reset;
    logic       p1_press;
    logic       p2_press;
    logic       win1;
    logic       win2;
    logic       play_en;
    logic       field_reset;
    logic [2:0] score1;
    logic [2:0] score2;
    logic [1:0] round_winner;
    logic       match_over;
    logic [1:0] champion;

    int total = 0;
    int bad   = 0;

    // Reference model of the registered results.
    logic [2:0] exp_s1;
    logic [2:0] exp_s2;
    logic [1:0] exp_rw;

    tow_match_ctrl #(
        .MAX_SCORE   (MAX),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p1_press     (p1_press),
        .p2_press     (p2_press),
        .win1         (win1),
        .win2         (win2),
        .play_en      (play_en),
        .field_reset  (field_reset),
        .score1       (score1),
        .score2       (score2),
        .round_winner (round_winner),
        .match_over   (match_over),
        .champion     (champion)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_score1"}, 8'(score1), 8'(exp_s1));
        chk({tag, "_score2"}, 8'(score2), 8'(exp_s2));
        chk({tag, "_rw"}, 8'(round_winner), 8'(exp_rw));
    endtask

    // One round from PLAY: apply wins for one cycle, then walk HOLD and
    // CLEAR (or DONE), optionally pulsing inputs that must be ignored.
    task automatic play_round(input logic w1, input logic w2, input bit noise);
        bit done_exp;
        win1 = w1;
        win2 = w2;
        tick();
        win1 = 1'b0;
        win2 = 1'b0;
        if (w1 && !w2) begin
            exp_s1 = (exp_s1 >= 3'(MAX)) ? 3'(MAX) : exp_s1 + 3'd1;
            exp_rw = 2'b01;
        end else if (w2 && !w1) begin
            exp_s2 = (exp_s2 >= 3'(MAX)) ? 3'(MAX) : exp_s2 + 3'd1;
            exp_rw = 2'b10;
        end else begin
            exp_rw = 2'b11;
        end
        done_exp = (exp_s1 == 3'(MAX)) || (exp_s2 == 3'(MAX));
        chk_results("win_plus1");
        chk("win_plus1_play_en", 8'(play_en), 8'd0);
        chk("win_plus1_field_reset", 8'(field_reset), 8'd0);
        for (int k = 2; k <= HOLD + 1; k++) begin
            if (noise) begin
                win2     = k[0];
                p1_press = ~k[0];
            end
            tick();
            win2     = 1'b0;
            p1_press = 1'b0;
            if (k <= HOLD) begin
                chk("hold_play_en", 8'(play_en), 8'd0);
                chk("hold_field_reset", 8'(field_reset), 8'd0);
                chk("hold_match_over", 8'(match_over), 8'd0);
            end
        end
        if (done_exp) begin
            chk("done_match_over", 8'(match_over), 8'd1);
            chk("done_champion", 8'(champion), (exp_s1 == 3'(MAX)) ? 8'd1 : 8'd2);
            chk("done_play_en", 8'(play_en), 8'd0);
            chk("done_field_reset", 8'(field_reset), 8'd0);
            chk_results("done");
        end else begin
            chk("clear_field_reset", 8'(field_reset), 8'd1);
            chk("clear_play_en", 8'(play_en), 8'd0);
            if (noise) begin
                win2     = 1'b1;
                p1_press = 1'b1;
            end
            tick();
            win2     = 1'b0;
            p1_press = 1'b0;
            chk("resume_play_en", 8'(play_en), 8'd1);
            chk("resume_field_reset", 8'(field_reset), 8'd0);
            chk_results("resume");
        end
    endtask

    initial begin
        reset    = 1'b1;
        p1_press = 1'b0;
        p2_press = 1'b0;
        win1     = 1'b0;
        win2     = 1'b0;
        exp_s1   = 3'd0;
        exp_s2   = 3'd0;
        exp_rw   = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state.
        chk("rst_play_en", 8'(play_en), 8'd0);
        chk("rst_field_reset", 8'(field_reset), 8'd1);
        chk("rst_match_over", 8'(match_over), 8'd0);
        chk("rst_champion", 8'(champion), 8'd0);
        chk_results("rst");

        // Computer press cannot start a match.
        p2_press = 1'b1;
        tick();
        p2_press = 1'b0;
        tick();
        chk("p2_idle_play_en", 8'(play_en), 8'd0);
        chk("p2_idle_field_reset", 8'(field_reset), 8'd1);

        // Player press starts play on the next cycle.
        p1_press = 1'b1;
        tick();
        p1_press = 1'b0;
        chk("start_play_en", 8'(play_en), 8'd1);
        chk("start_field_reset", 8'(field_reset), 8'd0);

        // P1 round win, then a draw, then P2 wins with noise during HOLD/CLEAR.
        play_round(1'b1, 1'b0, 1'b0);
        play_round(1'b1, 1'b1, 1'b0);
        play_round(1'b0, 1'b1, 1'b1);
        play_round(1'b0, 1'b1, 1'b0);
        play_round(1'b0, 1'b1, 1'b0);

        // DONE holds until a player press; computer press and wins are ignored.
        p2_press = 1'b1;
        win1     = 1'b1;
        tick();
        p2_press = 1'b0;
        win1     = 1'b0;
        tick();
        chk("done_hold_match_over", 8'(match_over), 8'd1);
        chk("done_hold_score2", 8'(score2), 8'd3);
        chk("done_hold_score1", 8'(score1), 8'd1);

        // Player press returns to IDLE and clears everything.
        p1_press = 1'b1;
        tick();
        p1_press = 1'b0;
        exp_s1 = 3'd0;
        exp_s2 = 3'd0;
        exp_rw = 2'b00;
        chk("new_match_over", 8'(match_over), 8'd0);
        chk("new_champion", 8'(champion), 8'd0);
        chk("new_field_reset", 8'(field_reset), 8'd1);
        chk("new_play_en", 8'(play_en), 8'd0);
        chk_results("new");

        // Reset in the middle of HOLD takes effect without a clock edge.
        p1_press = 1'b1;
        tick();
        p1_press = 1'b0;
        win1 = 1'b1;
        tick();
        win1 = 1'b0;
        chk("pre_rst_score1", 8'(score1), 8'd1);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        exp_s1 = 3'd0;
        exp_rw = 2'b00;
        chk("async_rst_field_reset", 8'(field_reset), 8'd1);
        chk("async_rst_play_en", 8'(play_en), 8'd0);
        chk_results("async_rst");
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 8'(field_reset), 8'd1);

        // A full round still plays normally afterwards.
        p1_press = 1'b1;
        tick();
        p1_press = 1'b0;
        chk("restart_play_en", 8'(play_en), 8'd1);
        play_round(1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
